// File: rtl/pe_array_ctrl.sv
// Sequencer for one row of systolic PEs: arms the row, feeds K kernel elements,
// waits for the far PE to finish and then reads the results out far column first.
module pe_array_ctrl #(
  parameter int unsigned COLS    = 8,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned KW      = 9,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [KW-1:0]            cfg_k_i,
  input  logic                     finish_in_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     en_synch_o,
  output logic                     en_pe_o,
  output logic [KW-1:0]            kernel_element_o,
  output logic [COLS-1:0]          sel_onehot_o,
  output logic                     rd_valid_o,
  output logic [$clog2(COLS)-1:0]  rd_idx_o
);

  localparam int unsigned IdxW = $clog2(COLS);
  localparam logic [KW-1:0]   KMax     = KW'(2 ** CNT_W);
  localparam logic [TO_W-1:0] ToLast   = TO_W'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(COLS - 1);
  localparam logic [COLS-1:0] SelFirst = COLS'(1) << (COLS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFeed,
    StWaitFin,
    StRead,
    StDone
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TO_W-1:0]  to_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             en_synch_q;
  logic             en_pe_q;
  logic [KW-1:0]    ke_q;
  logic [COLS-1:0]  sel_q;
  logic             rd_valid_q;
  logic [IdxW-1:0]  rd_idx_q;

  logic             k_ok;
  logic [KW-1:0]    k_last;

  assign k_ok   = (cfg_k_i != '0) && (cfg_k_i <= KMax);
  assign k_last = ke_q - KW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      to_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      en_synch_q <= 1'b0;
      en_pe_q    <= 1'b0;
      ke_q       <= '0;
      sel_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        // Abort beats every other transition; kernel_element keeps its value.
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        en_synch_q <= 1'b0;
        en_pe_q    <= 1'b0;
        sel_q      <= '0;
        rd_valid_q <= 1'b0;
        rd_idx_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (k_ok) begin
                ke_q       <= cfg_k_i;
                state_q    <= StArm;
                busy_q     <= 1'b1;
                en_synch_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          StArm: begin
            state_q <= StFeed;
            en_pe_q <= 1'b1;
            cnt_q   <= '0;
          end
          StFeed: begin
            if (KW'(cnt_q) == k_last) begin
              state_q <= StWaitFin;
              en_pe_q <= 1'b0;
              to_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StWaitFin: begin
            if (finish_in_i) begin
              state_q    <= StRead;
              sel_q      <= SelFirst;
              rd_valid_q <= 1'b1;
              rd_idx_q   <= IdxLast;
            end else if (to_q == ToLast) begin
              state_q    <= StIdle;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              en_synch_q <= 1'b0;
            end else if (to_q != '1) begin
              to_q <= to_q + TO_W'(1);
            end
          end
          StRead: begin
            // en_synch must stay high here or the PE result registers clear.
            if (rd_idx_q == '0) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              sel_q      <= '0;
              rd_valid_q <= 1'b0;
              en_synch_q <= 1'b0;
            end else begin
              rd_idx_q <= rd_idx_q - IdxW'(1);
              sel_q    <= sel_q >> 1;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign en_synch_o       = en_synch_q;
  assign en_pe_o          = en_pe_q;
  assign kernel_element_o = ke_q;
  assign sel_onehot_o     = sel_q;
  assign rd_valid_o       = rd_valid_q;
  assign rd_idx_o         = rd_idx_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: each job's expected output trace is built from the phase
// lengths (ARM 1, FEED K, WAIT n, READ COLS, DONE 1) and compared every cycle.
module tb_pe_array_ctrl;

  localparam int COLS    = 8;
  localparam int CNT_W   = 5;
  localparam int KW      = 9;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 200;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            err;
    logic            en_synch;
    logic            en_pe;
    logic [KW-1:0]   ke;
    logic [COLS-1:0] sel;
    logic            rd_valid;
    logic [2:0]      idx;
  } out_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [KW-1:0]   cfg_k;
  logic            finish_in;
  logic            busy;
  logic            done;
  logic            err;
  logic            en_synch;
  logic            en_pe;
  logic [KW-1:0]   kernel_element;
  logic [COLS-1:0] sel_onehot;
  logic            rd_valid;
  logic [2:0]      rd_idx;
  out_t            obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pe_array_ctrl #(
    .COLS    (COLS),
    .CNT_W   (CNT_W),
    .KW      (KW),
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .abort_i          (abort),
    .cfg_k_i          (cfg_k),
    .finish_in_i      (finish_in),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err),
    .en_synch_o       (en_synch),
    .en_pe_o          (en_pe),
    .kernel_element_o (kernel_element),
    .sel_onehot_o     (sel_onehot),
    .rd_valid_o       (rd_valid),
    .rd_idx_o         (rd_idx)
  );

  assign obs = {busy, done, err, en_synch, en_pe, kernel_element, sel_onehot, rd_valid, rd_idx};

  function automatic out_t idle_vec(input logic [KW-1:0] ke, input logic e);
    out_t v;
    v = '0;
    v.ke = ke;
    v.err = e;
    return v;
  endfunction

  // Expected outputs in cycle c of a job whose start was sampled in cycle 0.
  function automatic out_t exp_of(input int c, input int k, input int nf, input bit fin);
    out_t v;
    int rd0;
    int i;
    v = '0;
    v.ke = 9'(k);
    rd0 = k + 2 + nf;
    if (c == 1) begin
      v.busy = 1'b1;
      v.en_synch = 1'b1;
    end else if (c <= k + 1) begin
      v.busy = 1'b1;
      v.en_synch = 1'b1;
      v.en_pe = 1'b1;
    end else if (c < rd0) begin
      v.busy = 1'b1;
      v.en_synch = 1'b1;
    end else if (!fin) begin
      if (c == rd0) v.err = 1'b1;
    end else if (c < rd0 + COLS) begin
      i = c - rd0;
      v.busy = 1'b1;
      v.en_synch = 1'b1;
      v.sel = 8'h80 >> i;
      v.rd_valid = 1'b1;
      v.idx = 3'(COLS - 1 - i);
    end else if (c == rd0 + COLS) begin
      v.busy = 1'b1;
      v.done = 1'b1;
    end
    return v;
  endfunction

  task automatic step(input logic st, input logic ab, input logic fin, input logic [KW-1:0] cfg,
                      input out_t exp, input string tag);
    start = st;
    abort = ab;
    finish_in = fin;
    cfg_k = cfg;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_steps(input int n, input logic [KW-1:0] ke);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
           idle_vec(ke, 1'b0), "idle");
    end
  endtask

  // w: WAIT_FIN cycle index where finish_in rises (>= TIMEOUT: never).
  // a: cycle index carrying abort (-1: none). stop_at: return early after that cycle.
  task automatic job(input int k, input int w, input int a, input int stop_at, input bit noise,
                     input string tag);
    bit   fin;
    int   nf;
    int   last_c;
    int   pe_seen;
    int   done_seen;
    bit   aborted;
    bit   in_wait;
    logic st;
    logic fi;
    logic ab;
    out_t e;
    fin = (w < TIMEOUT);
    nf = fin ? w + 1 : TIMEOUT;
    last_c = fin ? k + 2 + nf + COLS + 1 : k + 2 + nf;
    pe_seen = 0;
    done_seen = 0;
    aborted = 1'b0;
    for (int t = 0; t < last_c; t++) begin
      in_wait = (t >= k + 2) && (t < k + 2 + nf);
      st = (t == 0) || (noise && ($urandom_range(0, 3) == 0));
      fi = in_wait ? (fin && (t == k + 2 + w)) : (noise && ($urandom_range(0, 2) == 0));
      ab = (t == a);
      e = (ab && t > 0) ? idle_vec(9'(k), 1'b0) : exp_of(t + 1, k, nf, fin);
      step(st, ab, fi, (t == 0) ? 9'(k) : 9'($urandom_range(0, 511)), e,
           $sformatf("%s@%0d", tag, t));
      if (en_pe) pe_seen++;
      if (done) done_seen++;
      if (ab && t > 0) begin
        aborted = 1'b1;
        break;
      end
      if (t == stop_at) return;
    end
    if (!aborted) begin
      vectors++;
      assert (pe_seen === k) else begin
        miscompares++;
        $error("FAIL %s_en_pe_len: observed %0d expected %0d", tag, pe_seen, k);
      end
      vectors++;
      assert (done_seen === int'(fin)) else begin
        miscompares++;
        $error("FAIL %s_done_cnt: observed %0d expected %0d", tag, done_seen, int'(fin));
      end
    end
  endtask

  initial begin
    int k;
    int w;
    int a;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_k = '0;
    finish_in = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    assert (obs === idle_vec('0, 1'b0)) else begin
      miscompares++;
      $error("FAIL reset: observed %h expected %h", obs, idle_vec('0, 1'b0));
    end
    rst_n = 1'b1;
    idle_steps(10, '0);

    job(9, 6, -1, -1, 1'b0, "k9");
    idle_steps(2, 9'd9);

    step(1'b1, 1'b0, 1'b0, 9'd0, idle_vec(9'd9, 1'b1), "bad_k0");
    step(1'b0, 1'b0, 1'b0, 9'd0, idle_vec(9'd9, 1'b0), "bad_k0_clr");
    step(1'b1, 1'b0, 1'b0, 9'd33, idle_vec(9'd9, 1'b1), "bad_k33");
    step(1'b0, 1'b0, 1'b0, 9'd0, idle_vec(9'd9, 1'b0), "bad_k33_clr");
    step(1'b1, 1'b1, 1'b0, 9'd511, idle_vec(9'd9, 1'b1), "bad_k511");
    idle_steps(1, 9'd9);

    job(32, TIMEOUT, -1, -1, 1'b0, "timeout");
    idle_steps(2, 9'd32);

    job(9, 6, 5, -1, 1'b0, "abort_feed");
    idle_steps(1, 9'd9);
    job(1, 3, -1, -1, 1'b0, "k1");
    idle_steps(1, 9'd1);

    job(8, 4, -1, -1, 1'b1, "noise");
    job(5, 2, 0, -1, 1'b0, "start_abort_idle");
    job(4, 1, 10, -1, 1'b0, "abort_read");
    job(3, 5, 1, -1, 1'b0, "abort_arm");
    job(6, 9, 10, -1, 1'b0, "abort_wait");
    job(1, TIMEOUT - 1, -1, -1, 1'b0, "fin_last_wait");
    job(32, 0, -1, -1, 1'b1, "k32_fin0");

    for (int n = 0; n < 12; n++) begin
      k = int'($urandom_range(1, 32));
      w = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, k + 2 + w + COLS)) : -1;
      job(k, w, a, -1, 1'b1, $sformatf("rnd%0d", n));
      idle_steps(int'($urandom_range(0, 2)), 9'(k));
    end

    job(6, 3, -1, 4, 1'b0, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    assert (obs === idle_vec('0, 1'b0)) else begin
      miscompares++;
      $error("FAIL async_reset: observed %h expected %h", obs, idle_vec('0, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(2, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
